serv_csr_seq: RTL and testbench

SERV_CSR_SEQ -- requirements
Module: serv_csr_seq

---
 rtl/serv_csr_seq_pkg.sv | 50 +++++
 rtl/serv_csr_seq_bitcnt.sv | 38 +++
 rtl/serv_csr_seq.sv | 145 ++++++++++++++
 tb/tb_serv_csr_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_csr_seq_pkg.sv
// Shared CSR sequencer definitions: CSR addresses, operand source codes, state type.
// No logic of its own; the decode helper is purely combinational.
// Used by the sequencer top and its address decoder.
package serv_csr_seq_pkg;

    // Machine-mode CSR addresses handled by this core
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    // Operand source selection for the CSR datapath
    localparam logic [1:0] SRC_CSR = 2'b00;
    localparam logic [1:0] SRC_EXT = 2'b01;
    localparam logic [1:0] SRC_SET = 2'b10;
    localparam logic [1:0] SRC_CLR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic mstatus;
        logic mie;
        logic mcause;
        logic rf;
    } csr_sel_t;

    // Map a CSR address onto its register select; all-zero means unimplemented
    function automatic csr_sel_t csr_decode(input logic [11:0] addr);
        csr_sel_t s;
        s = '0;
        case (addr)
            CSR_MSTATUS:  s.mstatus = 1'b1;
            CSR_MIE:      s.mie     = 1'b1;
            CSR_MCAUSE:   s.mcause  = 1'b1;
            CSR_MTVEC,
            CSR_MSCRATCH,
            CSR_MEPC,
            CSR_MTVAL:    s.rf      = 1'b1;
            default:      s         = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/serv_csr_seq_bitcnt.sv
// Beat counter and bit-position strobes for a 32-bit word moved W bits per beat.
// Strobes are decoded from the registered count; valid on the same cycle as the beat.
// No backpressure: counts every cycle while i_run is high, held at zero otherwise.
module serv_csr_bitcnt #(
    parameter int W = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_en,
    output logic o_cnt0to3,
    output logic o_cnt3,
    output logic o_cnt7,
    output logic o_cnt_done
);

    localparam int CW = $clog2(32 / W);
    localparam int B3 = 3 / W;   // beat carrying bit 3 (and last beat of bits 0-3)
    localparam int B7 = 7 / W;   // beat carrying bit 7

    logic [CW-1:0] r_cnt;

    // Count beats while running; the all-ones value wraps back to zero at the done beat
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_en       = i_run;
    assign o_cnt0to3  = i_run && (r_cnt <= CW'(B3));
    assign o_cnt3     = i_run && (r_cnt == CW'(B3));
    assign o_cnt7     = i_run && (r_cnt == CW'(B7));
    assign o_cnt_done = i_run && (r_cnt == {CW{1'b1}});

endmodule

// File: rtl/serv_csr_seq.sv
// CSR / trap / mret sequencer: arbitrates requests, runs 32/W beats, acks on the last beat.
// Legal request: RUN starts the cycle after acceptance; illegal CSR acks in the acceptance cycle.
// Requests are held by the requester until o_ack; new requests accepted only in IDLE.
module serv_csr_seq
    import serv_csr_seq_pkg::*;
#(
    parameter int    W              = 1,
    parameter string RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_csr_req,
    input  logic        i_trap_req,
    input  logic        i_mret_req,
    input  logic [11:0] i_csr_addr,
    input  logic [2:0]  i_funct3,
    input  logic        i_rs1_zero,
    output logic        o_busy,
    output logic        o_ack,
    output logic        o_illegal,
    output logic        o_en,
    output logic        o_cnt0to3,
    output logic        o_cnt3,
    output logic        o_cnt7,
    output logic        o_cnt_done,
    output logic        o_mstatus_en,
    output logic        o_mie_en,
    output logic        o_mcause_en,
    output logic        o_rf_csr_wen,
    output logic        o_trap,
    output logic        o_mret,
    output logic [1:0]  o_csr_source,
    output logic        o_csr_d_sel
);

    localparam bit RST_OPERANDS = (RESET_STRATEGY != "NONE");

    state_t   r_state;
    logic     r_trap;
    logic     r_mret;
    csr_sel_t r_sel;
    logic [1:0] r_source;
    logic     r_d_sel;

    csr_sel_t   w_dec;
    logic [1:0] w_src;
    logic       w_idle;
    logic       w_pick_trap;
    logic       w_pick_mret;
    logic       w_pick_csr;
    logic       w_csr_legal;
    logic       w_start;
    logic       w_illegal;
    logic       w_cnt_done;

    // Fixed priority: trap beats mret beats csr; losers simply stay asserted
    assign w_idle      = (r_state == ST_IDLE) && !i_rst;
    assign w_pick_trap = i_trap_req;
    assign w_pick_mret = !i_trap_req && i_mret_req;
    assign w_pick_csr  = !i_trap_req && !i_mret_req && i_csr_req;

    assign w_dec       = csr_decode(i_csr_addr);
    assign w_csr_legal = (|w_dec) && (i_funct3[1:0] != 2'b00);
    assign w_start     = w_idle && (w_pick_trap || w_pick_mret || (w_pick_csr && w_csr_legal));
    assign w_illegal   = w_idle && w_pick_csr && !w_csr_legal;

    // Operand source from the funct3 operation; set/clear with a zero mask is read-only
    always_comb begin
        w_src = SRC_CSR;
        case (i_funct3[1:0])
            2'b01:   w_src = SRC_EXT;
            2'b10:   w_src = i_rs1_zero ? SRC_CSR : SRC_SET;
            2'b11:   w_src = i_rs1_zero ? SRC_CSR : SRC_CLR;
            default: w_src = SRC_CSR;
        endcase
    end

    // Control FSM: latch request kind and register select at acceptance, drop them at done
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_trap  <= 1'b0;
            r_mret  <= 1'b0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_trap  <= w_pick_trap;
                        r_mret  <= w_pick_mret;
                        r_sel   <= w_pick_csr ? w_dec : '0;
                    end
                end
                ST_RUN: begin
                    if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                        r_trap  <= 1'b0;
                        r_mret  <= 1'b0;
                        r_sel   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand fields: only meaningful while busy, so their reset is optional
    always_ff @(posedge i_clk) begin
        if (i_rst && RST_OPERANDS) begin
            r_source <= SRC_CSR;
            r_d_sel  <= 1'b0;
        end else if (w_start) begin
            r_source <= w_pick_csr ? w_src : SRC_CSR;
            r_d_sel  <= w_pick_csr && i_funct3[2];
        end
    end

    serv_csr_bitcnt #(
        .W (W)
    ) u_bitcnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_run      (o_busy),
        .o_en       (o_en),
        .o_cnt0to3  (o_cnt0to3),
        .o_cnt3     (o_cnt3),
        .o_cnt7     (o_cnt7),
        .o_cnt_done (w_cnt_done)
    );

    assign o_busy       = (r_state == ST_RUN);
    assign o_cnt_done   = w_cnt_done;
    assign o_ack        = w_cnt_done || w_illegal;
    assign o_illegal    = w_illegal;
    assign o_mstatus_en = r_sel.mstatus;
    assign o_mie_en     = r_sel.mie;
    assign o_mcause_en  = r_sel.mcause;
    assign o_rf_csr_wen = r_sel.rf;
    assign o_trap       = r_trap;
    assign o_mret       = r_mret;
    assign o_csr_source = o_busy ? r_source : SRC_CSR;
    assign o_csr_d_sel  = o_busy && r_d_sel;

endmodule

// File: tb/tb_serv_csr_seq.sv
// Directed bench for serv_csr_seq at W=1, W=4 and W=8.
// Outputs sampled 1ns after the falling edge, inputs changed on the falling edge.
// Expected vectors are built per beat from hand-written strobe positions.
module tb_serv_csr_seq;

    typedef struct packed {
        logic        csr;
        logic        trap;
        logic        mret;
        logic [11:0] addr;
        logic [2:0]  f3;
        logic        rs1z;
    } req_t;

    typedef struct packed {
        logic       busy;
        logic       ack;
        logic       ill;
        logic       en;
        logic       c03;
        logic       c3;
        logic       c7;
        logic       done;
        logic       mst;
        logic       mie;
        logic       mc;
        logic       rf;
        logic       trap;
        logic       mret;
        logic [1:0] src;
        logic       dsel;
    } out_t;

    logic  clk;
    logic  rst;
    req_t  rq0, rq1, rq2;
    wire [16:0] ob0, ob1, ob2;

    int n_checks;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serv_csr_seq #(.W(1)) u_w1 (
        .i_clk(clk), .i_rst(rst),
        .i_csr_req(rq0.csr), .i_trap_req(rq0.trap), .i_mret_req(rq0.mret),
        .i_csr_addr(rq0.addr), .i_funct3(rq0.f3), .i_rs1_zero(rq0.rs1z),
        .o_busy(ob0[16]), .o_ack(ob0[15]), .o_illegal(ob0[14]), .o_en(ob0[13]),
        .o_cnt0to3(ob0[12]), .o_cnt3(ob0[11]), .o_cnt7(ob0[10]), .o_cnt_done(ob0[9]),
        .o_mstatus_en(ob0[8]), .o_mie_en(ob0[7]), .o_mcause_en(ob0[6]), .o_rf_csr_wen(ob0[5]),
        .o_trap(ob0[4]), .o_mret(ob0[3]), .o_csr_source(ob0[2:1]), .o_csr_d_sel(ob0[0])
    );

    serv_csr_seq #(.W(4)) u_w4 (
        .i_clk(clk), .i_rst(rst),
        .i_csr_req(rq1.csr), .i_trap_req(rq1.trap), .i_mret_req(rq1.mret),
        .i_csr_addr(rq1.addr), .i_funct3(rq1.f3), .i_rs1_zero(rq1.rs1z),
        .o_busy(ob1[16]), .o_ack(ob1[15]), .o_illegal(ob1[14]), .o_en(ob1[13]),
        .o_cnt0to3(ob1[12]), .o_cnt3(ob1[11]), .o_cnt7(ob1[10]), .o_cnt_done(ob1[9]),
        .o_mstatus_en(ob1[8]), .o_mie_en(ob1[7]), .o_mcause_en(ob1[6]), .o_rf_csr_wen(ob1[5]),
        .o_trap(ob1[4]), .o_mret(ob1[3]), .o_csr_source(ob1[2:1]), .o_csr_d_sel(ob1[0])
    );

    serv_csr_seq #(.W(8)) u_w8 (
        .i_clk(clk), .i_rst(rst),
        .i_csr_req(rq2.csr), .i_trap_req(rq2.trap), .i_mret_req(rq2.mret),
        .i_csr_addr(rq2.addr), .i_funct3(rq2.f3), .i_rs1_zero(rq2.rs1z),
        .o_busy(ob2[16]), .o_ack(ob2[15]), .o_illegal(ob2[14]), .o_en(ob2[13]),
        .o_cnt0to3(ob2[12]), .o_cnt3(ob2[11]), .o_cnt7(ob2[10]), .o_cnt_done(ob2[9]),
        .o_mstatus_en(ob2[8]), .o_mie_en(ob2[7]), .o_mcause_en(ob2[6]), .o_rf_csr_wen(ob2[5]),
        .o_trap(ob2[4]), .o_mret(ob2[3]), .o_csr_source(ob2[2:1]), .o_csr_d_sel(ob2[0])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic out_t get_out(input int i);
        case (i)
            0:       return out_t'(ob0);
            1:       return out_t'(ob1);
            default: return out_t'(ob2);
        endcase
    endfunction

    task automatic set_req(input int i, input req_t r);
        case (i)
            0:       rq0 = r;
            1:       rq1 = r;
            default: rq2 = r;
        endcase
    endtask

    function automatic req_t mk_req(input logic csr, input logic trap, input logic mret,
                                    input logic [11:0] addr, input logic [2:0] f3,
                                    input logic rs1z);
        req_t r;
        r.csr = csr; r.trap = trap; r.mret = mret;
        r.addr = addr; r.f3 = f3; r.rs1z = rs1z;
        return r;
    endfunction

    // Sample one cycle: change inputs on the falling edge, then look 1ns later
    task automatic idle_chk(input int i, input string tag);
        @(negedge clk);
        #1;
        chk(tag, 32'(get_out(i)), 32'(out_t'('0)));
    endtask

    // Check every beat of one run; 'base' carries the fields constant across the run
    task automatic run_seq(input int i, input int w, input out_t base, input string tag,
                           input req_t nxt);
        int   last;
        out_t e;
        last = 32 / w - 1;
        for (int b = 0; b <= last; b++) begin
            @(negedge clk);
            #1;
            e      = base;
            e.busy = 1'b1;
            e.en   = 1'b1;
            case (w)
                1: begin e.c03 = (b < 4);  e.c3 = (b == 3); e.c7 = (b == 7); end
                4: begin e.c03 = (b == 0); e.c3 = (b == 0); e.c7 = (b == 1); end
                default: begin e.c03 = (b == 0); e.c3 = (b == 0); e.c7 = (b == 0); end
            endcase
            e.done = (b == last);
            e.ack  = (b == last);
            chk($sformatf("%s.beat%0d", tag, b), 32'(get_out(i)), 32'(e));
            if (b == last) set_req(i, nxt);
        end
    endtask

    out_t base;
    out_t e;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        rq0 = '0; rq1 = '0; rq2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.w1", 32'(get_out(0)), 32'(out_t'('0)));
        chk("reset.w4", 32'(get_out(1)), 32'(out_t'('0)));
        chk("reset.w8", 32'(get_out(2)), 32'(out_t'('0)));

        // W=1: csrrw mstatus, 32 beats, source EXT
        @(negedge clk);
        rq0 = mk_req(1'b1, 1'b0, 1'b0, 12'h300, 3'b001, 1'b0);
        #1;
        chk("A.accept", 32'(get_out(0)), 32'(out_t'('0)));
        base = '0; base.mst = 1'b1; base.src = 2'b01;
        run_seq(0, 1, base, "A", '0);
        idle_chk(0, "A.after");

        // W=4: trap and csrrc mie together; trap first, csr after one idle cycle
        @(negedge clk);
        rq1 = mk_req(1'b1, 1'b1, 1'b0, 12'h304, 3'b011, 1'b0);
        #1;
        chk("B.accept", 32'(get_out(1)), 32'(out_t'('0)));
        base = '0; base.trap = 1'b1; base.src = 2'b00;
        run_seq(1, 4, base, "B.trap", mk_req(1'b1, 1'b0, 1'b0, 12'h304, 3'b011, 1'b0));
        idle_chk(1, "B.gap");
        base = '0; base.mie = 1'b1; base.src = 2'b11;
        run_seq(1, 4, base, "B.csr", '0);
        idle_chk(1, "B.after");

        // Illegal address: ack+illegal in the acceptance cycle, never runs
        @(negedge clk);
        rq0 = mk_req(1'b1, 1'b0, 1'b0, 12'h7C0, 3'b010, 1'b0);
        #1;
        e = '0; e.ack = 1'b1; e.ill = 1'b1;
        chk("C.ack", 32'(get_out(0)), 32'(e));
        @(negedge clk);
        rq0 = '0;
        #1;
        chk("C.idle0", 32'(get_out(0)), 32'(out_t'('0)));
        idle_chk(0, "C.idle1");
        // Legal address but funct3 operation 00 is also rejected
        @(negedge clk);
        rq0 = mk_req(1'b1, 1'b0, 1'b0, 12'h300, 3'b000, 1'b0);
        #1;
        chk("C2.ack", 32'(get_out(0)), 32'(e));
        @(negedge clk);
        rq0 = '0;
        #1;
        chk("C2.idle", 32'(get_out(0)), 32'(out_t'('0)));

        // W=8: csrrsi mcause with zimm=0 -> read-only, immediate select
        @(negedge clk);
        rq2 = mk_req(1'b1, 1'b0, 1'b0, 12'h342, 3'b110, 1'b1);
        #1;
        chk("D.accept", 32'(get_out(2)), 32'(out_t'('0)));
        base = '0; base.mc = 1'b1; base.src = 2'b00; base.dsel = 1'b1;
        run_seq(2, 8, base, "D", '0);
        idle_chk(2, "D.after");

        // W=8: mret beats a simultaneous csr request
        @(negedge clk);
        rq2 = mk_req(1'b1, 1'b0, 1'b1, 12'h341, 3'b001, 1'b0);
        #1;
        chk("M.accept", 32'(get_out(2)), 32'(out_t'('0)));
        base = '0; base.mret = 1'b1;
        run_seq(2, 8, base, "M", '0);
        idle_chk(2, "M.after");

        // W=1: reset at beat 10 aborts the run, then a fresh request completes
        @(negedge clk);
        rq0 = mk_req(1'b1, 1'b0, 1'b0, 12'h305, 3'b101, 1'b0);
        #1;
        chk("E.accept", 32'(get_out(0)), 32'(out_t'('0)));
        repeat (10) @(negedge clk);
        #1;
        e = '0; e.busy = 1'b1; e.en = 1'b1; e.rf = 1'b1; e.src = 2'b01; e.dsel = 1'b1;
        chk("E.beat10", 32'(get_out(0)), 32'(e));
        rst = 1'b1;
        rq0 = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("E.rst", 32'(get_out(0)), 32'(out_t'('0)));
        idle_chk(0, "E.noack0");
        idle_chk(0, "E.noack1");
        @(negedge clk);
        rq0 = mk_req(1'b1, 1'b0, 1'b0, 12'h305, 3'b101, 1'b0);
        #1;
        chk("E.reaccept", 32'(get_out(0)), 32'(out_t'('0)));
        base = '0; base.rf = 1'b1; base.src = 2'b01; base.dsel = 1'b1;
        run_seq(0, 1, base, "E.fresh", '0);
        idle_chk(0, "E.after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
